exc_sched: RTL and testbench

//  Exception/interrupt scheduler in front of the CP0 register file. Picks the

---
 rtl/exc_sched.sv | 86 ++++++++
 tb/tb_exc_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler ahead of CP0: picks the event committed this
// cycle, drives CP0 exccode/pc/in_delay, then holds off while the pipeline refills.
module exc_sched #(
  parameter int              INT_W    = 6,
  parameter int              EXC_W    = 5,
  parameter int              HOLDOFF  = 2,
  parameter logic [EXC_W-1:0] EXC_NONE = 5'h10,
  parameter logic [EXC_W-1:0] EXC_INT  = 5'h00
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic [INT_W-1:0] int_raw,
  input  logic [31:0]      status_i,
  input  logic             mem_valid,
  input  logic [31:0]      mem_pc,
  input  logic             mem_in_delay,
  input  logic [EXC_W-1:0] mem_exccode,
  output logic [EXC_W-1:0] exccode_o,
  output logic [31:0]      pc_o,
  output logic             in_delay_o,
  output logic [INT_W-1:0] int_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2((HOLDOFF > 1) ? HOLDOFF : 2);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [INT_W-1:0] r_sync1, r_sync2;

  logic             w_int_pend;
  logic             w_idle;
  logic             w_take;
  logic [EXC_W-1:0] w_code;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= int_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_int_pend = status_i[0] & ~status_i[1] & (|(r_sync2 & status_i[10 +: INT_W]));
  assign w_idle     = (r_state == S_IDLE) & ~cpu_rst;

  // Interrupts need a real victim PC, so bubbles never commit anything.
  always_comb begin
    w_code = EXC_NONE;
    if (w_idle && mem_valid) begin
      if (w_int_pend)                    w_code = EXC_INT;
      else if (mem_exccode != EXC_NONE)  w_code = mem_exccode;
    end
  end

  assign w_take     = (w_code != EXC_NONE);
  assign exccode_o  = w_code;
  assign pc_o       = w_take ? mem_pc : 32'h0;
  assign in_delay_o = w_take & mem_in_delay;
  assign int_o      = cpu_rst ? '0 : r_sync2;
  assign busy_o     = (r_state == S_HOLD) & ~cpu_rst;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_take) begin
          r_state <= S_HOLD;
          r_cnt   <= CNT_W'(HOLDOFF - 1);
        end
        S_HOLD: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_sched.sv
// Cycle-by-cycle vector table for exc_sched; expectations queued on drive and
// popped at the falling edge, plus a hand-written synchroniser latency probe.
module tb_exc_sched;

  localparam logic [4:0] N = 5'h10;
  localparam logic [31:0] A  = 32'h0000_0401;
  localparam logic [31:0] AX = 32'h0000_0403;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_raw;
  logic [31:0] status;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay;
  logic [4:0]  mem_exccode;
  logic [4:0]  exccode_o;
  logic [31:0] pc_o;
  logic        in_delay_o;
  logic [5:0]  int_o;
  logic        busy_o;

  always #5 clk = ~clk;

  exc_sched dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .int_raw     (int_raw),
    .status_i    (status),
    .mem_valid   (mem_valid),
    .mem_pc      (mem_pc),
    .mem_in_delay(mem_in_delay),
    .mem_exccode (mem_exccode),
    .exccode_o   (exccode_o),
    .pc_o        (pc_o),
    .in_delay_o  (in_delay_o),
    .int_o       (int_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  ir;
    logic [31:0] st;
    logic        mv;
    logic [31:0] pc;
    logic        dl;
    logic [4:0]  ec;
    logic [4:0]  x_exc;
    logic [31:0] x_pc;
    logic        x_dl;
    logic [5:0]  x_int;
    logic        x_busy;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic        dl;
    logic [5:0]  intr;
    logic        busy;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic void add(logic r, logic [5:0] ir, logic [31:0] st, logic mv,
                              logic [31:0] pc, logic dl, logic [4:0] ec,
                              logic [4:0] xe, logic [31:0] xp, logic xd,
                              logic [5:0] xi, logic xb);
    vec_t v;
    v.rst = r; v.ir = ir; v.st = st; v.mv = mv; v.pc = pc; v.dl = dl; v.ec = ec;
    v.x_exc = xe; v.x_pc = xp; v.x_dl = xd; v.x_int = xi; v.x_busy = xb;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   lat;

    rst = 1'b1; int_raw = 6'h3F; status = '0; mem_valid = 1'b0;
    mem_pc = '0; mem_in_delay = 1'b0; mem_exccode = N;

    // reset with all lines high, then sync latency
    add(1, 6'h3F, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    add(1, 6'h3F, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    add(1, 6'h3F, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    add(0, 6'h3F, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    add(0, 6'h3F, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    add(0, 6'h00, 0, 0, 0, 0, N,   N, 0, 0, 6'h3F, 0);
    add(0, 6'h00, 0, 0, 0, 0, N,   N, 0, 0, 6'h3F, 0);
    add(0, 6'h00, 0, 0, 0, 0, N,   N, 0, 0, 6'h00, 0);
    // interrupt taken once synchronised, then HOLD ignores mem exception
    add(0, 6'h01, A, 1, 32'h100, 0, N,     N,     0,       0, 6'h00, 0);
    add(0, 6'h01, A, 1, 32'h100, 0, N,     N,     0,       0, 6'h00, 0);
    add(0, 6'h01, A, 1, 32'h100, 0, N,     5'h00, 32'h100, 0, 6'h01, 0);
    add(0, 6'h01, A, 1, 32'h100, 0, 5'h0C, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, A, 1, 32'h100, 0, 5'h0C, N,     0,       0, 6'h01, 1);
    // bubble blocks pending interrupt; valid takes it; reset in HOLD
    add(0, 6'h01, A, 0, 32'h100, 0, N,     N,     0,       0, 6'h01, 0);
    add(0, 6'h01, A, 1, 32'h200, 0, N,     5'h00, 32'h200, 0, 6'h01, 0);
    add(1, 6'h01, A, 1, 32'h200, 0, N,     N,     0,       0, 6'h00, 0);
    add(0, 6'h01, A, 0, 32'h0,   0, N,     N,     0,       0, 6'h00, 0);
    add(0, 6'h01, A, 0, 32'h0,   0, N,     N,     0,       0, 6'h00, 0);
    add(0, 6'h01, A, 0, 32'h0,   0, N,     N,     0,       0, 6'h01, 0);
    // collision: interrupt beats mem exception, delay slot forwarded
    add(0, 6'h01, A, 1, 32'h300, 1, 5'h0C, 5'h00, 32'h300, 1, 6'h01, 0);
    add(0, 6'h01, A, 1, 32'h300, 1, 5'h0C, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, A, 1, 32'h300, 1, 5'h0C, N,     0,       0, 6'h01, 1);
    // masked by EXL, by IM=0
    add(0, 6'h01, AX,          1, 32'h400, 0, N, N, 0, 0, 6'h01, 0);
    add(0, 6'h01, 32'h1,       1, 32'h400, 0, N, N, 0, 0, 6'h01, 0);
    add(0, 6'h01, AX,          1, 32'h400, 0, N, N, 0, 0, 6'h01, 0);
    // ERET, second ERET swallowed by holdoff, then accepted again
    add(0, 6'h01, 0, 1, 32'h500, 0, 5'h11, 5'h11, 32'h500, 0, 6'h01, 0);
    add(0, 6'h01, 0, 1, 32'h500, 0, 5'h11, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, 0, 1, 32'h500, 0, 5'h11, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, 0, 1, 32'h600, 0, 5'h11, 5'h11, 32'h600, 0, 6'h01, 0);
    add(0, 6'h01, 0, 0, 32'h600, 0, 5'h11, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, 0, 0, 32'h600, 0, 5'h11, N,     0,       0, 6'h01, 1);
    // out-of-range code passes through even with EXL=1
    add(0, 6'h01, AX, 1, 32'h700, 1, 5'h1F, 5'h1F, 32'h700, 1, 6'h01, 0);
    add(0, 6'h01, AX, 1, 32'h700, 1, 5'h1F, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, AX, 1, 32'h700, 1, 5'h1F, N,     0,       0, 6'h01, 1);
    add(0, 6'h01, AX, 1, 32'h700, 1, N,     N,     0,       0, 6'h01, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst = tv[i].rst; int_raw = tv[i].ir; status = tv[i].st; mem_valid = tv[i].mv;
      mem_pc = tv[i].pc; mem_in_delay = tv[i].dl; mem_exccode = tv[i].ec;
      e.cyc = i; e.exc = tv[i].x_exc; e.pc = tv[i].x_pc; e.dl = tv[i].x_dl;
      e.intr = tv[i].x_int; e.busy = tv[i].x_busy;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk("exccode", e.cyc, 32'(exccode_o), 32'(e.exc));
      chk("pc",      e.cyc, pc_o,           e.pc);
      chk("in_delay",e.cyc, 32'(in_delay_o),32'(e.dl));
      chk("int_o",   e.cyc, 32'(int_o),     32'(e.intr));
      chk("busy",    e.cyc, 32'(busy_o),    32'(e.busy));
    end

    // synchroniser latency probe from a clean reset
    @(posedge clk); #1;
    rst = 1'b1; int_raw = 6'h00; status = '0; mem_valid = 1'b0; mem_exccode = N;
    @(posedge clk); #1;
    rst = 1'b0; int_raw = 6'h04;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (int_o === 6'h04) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++; n_err++;
      $display("FAIL sync_timeout actual=none required=int_o 04 within 10 cycles");
    end else begin
      chk("sync_latency", lat, 32'(lat), 32'd2);
    end
    chk("probe_busy", 0, 32'(busy_o), 32'd0);
    chk("probe_exc",  0, 32'(exccode_o), 32'(N));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
